// File: rtl/ram_stream_reader.sv
// ============================================================================
//  Module   : ram_stream_reader
//  Purpose  : Walks a block of words out of a buffer RAM read port and presents
//             each word on a valid/ready stream toward a serial transmitter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_stream_reader #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 8
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_start,
  input  logic                      in_abort,
  input  logic [RAM_ADDR_WIDTH-1:0] in_base_addr,
  input  logic [RAM_ADDR_WIDTH:0]   in_length,
  output logic [RAM_ADDR_WIDTH-1:0] out_ram_addr,
  input  logic [RAM_DATA_WIDTH-1:0] in_ram_data,
  output logic [RAM_DATA_WIDTH-1:0] out_tx_data,
  output logic                      out_tx_valid,
  input  logic                      in_tx_ready,
  output logic                      out_busy,
  output logic                      out_done
);

  // Remaining-word counter is one bit wider than the address so a full-depth
  // transfer (2**AW words) fits.
  localparam logic [RAM_ADDR_WIDTH:0]   c_REM_ONE  = 1;
  localparam logic [RAM_ADDR_WIDTH:0]   c_REM_ZERO = 0;
  localparam logic [RAM_ADDR_WIDTH-1:0] c_ADDR_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // waiting for a start command
    S_WAIT = 2'd1,  // RAM samples the address on this edge
    S_CAPT = 2'd2,  // RAM data is available; capture it into the stream
    S_HOLD = 2'd3   // word presented, waiting for the consumer
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [RAM_ADDR_WIDTH-1:0]   r_addr;
  logic [RAM_ADDR_WIDTH:0]     r_remaining;
  logic [RAM_DATA_WIDTH-1:0]   r_data;
  logic                        r_valid;
  logic                        r_busy;
  logic                        r_done;
  logic                        w_handshake;
  logic                        w_last;

  assign w_handshake = r_valid & in_tx_ready;
  assign w_last      = (r_remaining == c_REM_ONE);

  // State register.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort out of any active state wins over a handshake.
  always_comb begin
    w_state_next = r_state;
    if (r_state != S_IDLE && in_abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (in_start && in_length != c_REM_ZERO) w_state_next = S_WAIT;
        S_WAIT: w_state_next = S_CAPT;
        S_CAPT: w_state_next = S_HOLD;
        S_HOLD: if (w_handshake) w_state_next = w_last ? S_IDLE : S_WAIT;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs: address, counter, stream word, flags.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && in_abort) begin
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (in_start) begin
              if (in_length != c_REM_ZERO) begin
                r_addr      <= in_base_addr;
                r_remaining <= in_length;
                r_busy      <= 1'b1;
              end else begin
                // Zero-length request completes immediately with no data.
                r_done <= 1'b1;
              end
            end
          end
          S_CAPT: begin
            r_data  <= in_ram_data;
            r_valid <= 1'b1;
          end
          S_HOLD: begin
            if (w_handshake) begin
              r_valid     <= 1'b0;
              r_remaining <= r_remaining - c_REM_ONE;
              if (w_last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
              end else begin
                r_addr <= r_addr + c_ADDR_ONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_ram_addr = r_addr;
  assign out_tx_data  = r_data;
  assign out_tx_valid = r_valid;
  assign out_busy     = r_busy;
  assign out_done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// ============================================================================
//  Module   : tb_ram_stream_reader
//  Purpose  : Directed self-checking bench for ram_stream_reader with a
//             registered-read RAM model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] base = 8'h00;
  logic [8:0] len = 9'd0;
  logic [7:0] ram_addr;
  logic [7:0] ram_q = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       done;

  logic [7:0] mem [0:255];

  int checks = 0;
  int failures = 0;

  logic [7:0] got[$];
  logic [7:0] gaddr[$];
  int n_done;
  int first_v;
  int saw_busy;
  int overlap;
  int timed_out;

  always #5 clk = ~clk;

  // Buffer RAM read port with one cycle of latency.
  always @(posedge clk) ram_q <= mem[ram_addr];

  ram_stream_reader #(.RAM_ADDR_WIDTH(8), .RAM_DATA_WIDTH(8)) dut (
    .in_clk       (clk),
    .in_rst       (rst),
    .in_start     (start),
    .in_abort     (abort),
    .in_base_addr (base),
    .in_length    (len),
    .out_ram_addr (ram_addr),
    .in_ram_data  (ram_q),
    .out_tx_data  (tx_data),
    .out_tx_valid (tx_valid),
    .in_tx_ready  (tx_ready),
    .out_busy     (busy),
    .out_done     (done)
  );

  // Start a transfer with ready held high and record every accepted word.
  task automatic run_xfer(input logic [7:0] b, input logic [8:0] l, input int budget);
    int after_done;
    got.delete(); gaddr.delete();
    n_done = 0; first_v = -1; saw_busy = 0; overlap = 0; after_done = -1;
    tx_ready = 1'b1; base = b; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (busy) saw_busy = 1;
      if (busy && done) overlap++;
      if (done) n_done++;
      if (tx_valid && first_v < 0) first_v = c;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        gaddr.push_back(ram_addr);
      end
      if (done && after_done < 0) after_done = 0;
      else if (after_done >= 0) after_done++;
      if (after_done > 4) break;
      @(negedge clk);
    end
    timed_out = (n_done == 0) ? 1 : 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", tx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (ram_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", ram_addr); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", tx_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp [4];
    exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
    run_xfer(8'h10, 9'd4, 60);
    checks++; if (timed_out != 0) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
    checks++; if (got.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL basic_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    checks++; if (first_v != 2) begin failures++; $display("FAIL basic_first_valid got=%0d exp=2", first_v); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
    checks++; if (overlap != 0) begin failures++; $display("FAIL basic_busy_done_overlap got=%0d exp=0", overlap); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [4];
    int k;
    exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    got.delete(); n_done = 0;
    tx_ready = 1'b0; base = 8'h10; len = 9'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 10 && !tx_valid; k++) @(negedge clk);
    checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_timeout got=%b exp=1", tx_valid); end
    for (int s = 0; s < 5; s++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA)
        begin failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1/aa", s, tx_valid, tx_data); end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (done) begin n_done++; break; end
      @(negedge clk);
    end
    checks++; if (got.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    checks++; if (n_done != 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", n_done); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d [4];
    logic [7:0] exp_a [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    run_xfer(8'hFE, 9'd4, 60);
    checks++; if (got.size() != 4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_d[i]) begin failures++; $display("FAIL wrap_word%0d got=%h exp=%h", i, got[i], exp_d[i]); end
      checks++; if (gaddr[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, gaddr[i], exp_a[i]); end
    end
  endtask

  task automatic test_lengths();
    logic [7:0] e;
    int bad;
    run_xfer(8'h20, 9'd0, 20);
    checks++; if (n_done != 1) begin failures++; $display("FAIL len0_done got=%0d exp=1", n_done); end
    checks++; if (first_v != -1) begin failures++; $display("FAIL len0_valid got=%0d exp=-1", first_v); end
    checks++; if (saw_busy != 0) begin failures++; $display("FAIL len0_busy got=%0d exp=0", saw_busy); end
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 7) + 3);
    run_xfer(8'h00, 9'd256, 1000);
    checks++; if (got.size() != 256) begin failures++; $display("FAIL len256_count got=%0d exp=256", got.size()); end
    bad = 0;
    for (int i = 0; i < got.size() && i < 256; i++) begin
      e = 8'((i * 7) + 3);
      if (got[i] !== e) begin
        if (bad == 0) $display("FAIL len256_word%0d got=%h exp=%h", i, got[i], e);
        bad++;
      end
    end
    checks++; if (bad != 0) failures++;
    checks++; if (n_done != 1) begin failures++; $display("FAIL len256_done got=%0d exp=1", n_done); end
    checks++; if (overlap != 0) begin failures++; $display("FAIL len256_overlap got=%0d exp=0", overlap); end
  endtask

  task automatic test_abort();
    int hs;
    int k;
    int bad_after;
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
    got.delete(); hs = 0;
    tx_ready = 1'b1; base = 8'h10; len = 9'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && hs < 2; c++) begin
      if (tx_valid && tx_ready) begin got.push_back(tx_data); hs++; end
      start = (c == 1) ? 1'b1 : 1'b0;
      if (c == 1) begin base = 8'h80; len = 9'd2; end
      @(negedge clk);
    end
    start = 1'b0;
    tx_ready = 1'b0;
    for (k = 0; k < 10 && !tx_valid; k++) @(negedge clk);
    checks++; if (got.size() != 2 || got[0] !== 8'hAA || got[1] !== 8'hBB)
      begin failures++; $display("FAIL abort_prefix got=%0d words exp=aa,bb", got.size()); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hCC)
      begin failures++; $display("FAIL abort_third got=%b/%h exp=1/cc", tx_valid, tx_data); end
    abort = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", tx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    bad_after = 0;
    for (int c = 0; c < 6; c++) begin
      if (done || tx_valid || busy) bad_after++;
      @(negedge clk);
    end
    checks++; if (bad_after != 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", bad_after); end
    run_xfer(8'h10, 9'd4, 60);
    checks++; if (got.size() != 4 || got[0] !== 8'hAA || got[3] !== 8'hDD || n_done != 1)
      begin failures++; $display("FAIL abort_restart got=%0d words done=%0d exp=4/1", got.size(), n_done); end
  endtask

  task automatic test_async_reset();
    int k;
    tx_ready = 1'b0; base = 8'h12; len = 9'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 10 && !tx_valid; k++) @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hCC)
      begin failures++; $display("FAIL ar_hold got=%b/%h exp=1/cc", tx_valid, tx_data); end
    #1 rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_addr !== 8'h00 || tx_data !== 8'h00)
      begin failures++; $display("FAIL ar_clear got=v%b b%b d%b a%h q%h exp=all0", tx_valid, busy, done, ram_addr, tx_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_xfer(8'h10, 9'd2, 40);
    checks++; if (got.size() != 2 || got[0] !== 8'hAA || got[1] !== 8'hBB || n_done != 1)
      begin failures++; $display("FAIL ar_restart got=%0d words done=%0d exp=2/1", got.size(), n_done); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_lengths();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
